vga_timing_det: RTL
===================

VGA_TIMING_DET -- requirements
Module: vga_timing_det

Interface
REQ-001 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-002 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-003 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-004 Parameter H_TOTAL, 800, nominal pixels per line.
REQ-005 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-006 Parameter V_BACK, 33, vertical back porch in lines.
REQ-007 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-008 Parameter V_TOTAL, 525, nominal lines per frame.
REQ-009 Parameter SYNC_POL, 0, asserted level of hsync/vsync.
REQ-010 Port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-011 Port sys_rst, input, 1, synchronous active-high reset.
REQ-012 Port pix_en, input, 1, one-cycle pixel-rate enable (25 MHz rate from 50 MHz sys_clk).
REQ-013 Port hsync, input, 1, incoming horizontal sync, asynchronous.
REQ-014 Port vsync, input, 1, incoming vertical sync, asynchronous.
REQ-015 Port pix_x, output, 10, active-area column, 0 when not active.
REQ-016 Port pix_y, output, 10, active-area row, 0 when not active.
REQ-017 Port active, output, 1, high while locked and inside the visible window.
REQ-018 Port h_total, output, 11, pixel count of the last complete line.
REQ-019 Port v_total, output, 10, line count of the last complete frame.
REQ-020 Port locked, output, 1, timing matches nominal.
REQ-021 Port frame_start, output, 1, one-cycle pulse on a vsync leading edge.

Function
REQ-022 hsync/vsync SHALL pass a 2-flop sys_clk synchronizer; the previous-value register for edge detection SHALL update only on pix_en cycles.
REQ-023 Leading edge = pix_en cycle where synced value equals SYNC_POL and previous value does not.
REQ-024 h_cnt (11 bit) SHALL increment per pix_en, load 0 the cycle after an hsync leading edge, and saturate at 2047.
REQ-025 On an hsync leading edge, h_total SHALL load h_cnt+1 and v_cnt (10 bit) SHALL increment, saturating at 1023.
REQ-026 On a vsync leading edge, v_total SHALL load v_cnt+1, v_cnt SHALL load 0 and frame_start SHALL pulse for that single cycle, regardless of lock.
REQ-027 Simultaneous h and v leading edges: v_cnt SHALL load 0 (vsync wins), h_cnt SHALL load 0.
REQ-028 Lock FSM states SEARCH, TRACK, LOCKED; reset state SEARCH.
REQ-029 SEARCH -> TRACK on a vsync leading edge; the line-mismatch flag clears.
REQ-030 TRACK: any hsync leading edge with h_cnt+1 != H_TOTAL sets the mismatch flag; on the next vsync edge -> LOCKED if flag clear and v_cnt+1 == V_TOTAL, else stay TRACK with flag cleared.
REQ-031 LOCKED -> SEARCH on any line-length mismatch, frame-length mismatch, or h_cnt/v_cnt saturation.
REQ-032 locked SHALL be high exactly while the state is LOCKED, registered (one cycle after the transition).
REQ-033 active SHALL equal locked AND h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE), registered.
REQ-034 pix_x = h_cnt-(H_SYNC+H_BACK), pix_y = v_cnt-(V_SYNC+V_BACK), registered alongside active; both 0 when active is low.
REQ-035 Without pix_en, counters, FSM and outputs SHALL hold (frame_start SHALL be 0).

Reset
REQ-036 When sys_rst is high at a sys_clk edge: state SEARCH; h_cnt, v_cnt, pix_x, pix_y, h_total, v_total 0; active, locked, frame_start 0; synchronizer and previous-value registers set to !SYNC_POL.
REQ-037 Reset mid-frame SHALL drop locked the following cycle; relock requires one full SEARCH->TRACK->LOCKED sequence.

Structure
REQ-038 The timing constants (640x480@60 defaults) and the lock-state enumeration SHALL live in the shared package vga_pkg.
REQ-039 Synchronizer plus edge detector SHALL be a sub-module sync_edge, instantiated once for hsync and once for vsync.

Verification
REQ-040 Nominal 800x525 stream, pix_en every 2nd cycle -> locked rises after second vsync edge; h_total=800, v_total=525.
REQ-041 Locked stream, pixel h_cnt=144 on line v_cnt=35 -> active=1, pix_x=0, pix_y=0; h_cnt=783 -> pix_x=639; h_cnt=784 -> active=0.
REQ-042 Locked stream, one line of 801 pixels -> h_total=801, locked=0 next cycle, relock after two further good frames.
REQ-043 hsync held deasserted for 3000 pixels while locked -> h_cnt saturates at 2047, locked=0.
REQ-044 sys_rst pulsed mid-frame -> all outputs 0 next cycle, frame_start pulses on next vsync edge, locked returns after TRACK frame.
REQ-045 hsync and vsync leading edges on the same pix_en cycle -> v_cnt=0, h_cnt=0, single frame_start pulse.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared timing constants (640x480@60 defaults) and the lock-state
//            enumeration used by the VGA timing detector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // Nominal 640x480@60 timing, in pixels / lines
   localparam int unsigned C_H_SYNC   = 96;
   localparam int unsigned C_H_BACK   = 48;
   localparam int unsigned C_H_ACTIVE = 640;
   localparam int unsigned C_H_TOTAL  = 800;
   localparam int unsigned C_V_SYNC   = 2;
   localparam int unsigned C_V_BACK   = 33;
   localparam int unsigned C_V_ACTIVE = 480;
   localparam int unsigned C_V_TOTAL  = 525;
   localparam logic        C_SYNC_POL = 1'b0;

   // Counter ceilings; the counters stick here instead of wrapping
   localparam logic [10:0] C_H_CNT_MAX = 11'd2047;
   localparam logic [9:0]  C_V_CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_det_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer for an asynchronous sync input followed by
//            a pixel-rate leading-edge detector.
// Ports    : sys_clk  - clock
//            sys_rst  - synchronous active-high reset
//            pix_en   - pixel-rate enable
//            async_in - asynchronous sync input
//            lead     - high on the pix_en cycle of a leading edge
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
   parameter logic SYNC_POL = 1'b0
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic pix_en,
   input  logic async_in,
   output logic lead
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      // The previous value advances only at pixel rate so that an edge is
      // reported on exactly one pix_en cycle.
      prev_d = pix_en ? sync_q : prev_q;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         meta_q <= ~SYNC_POL;
         sync_q <= ~SYNC_POL;
         prev_q <= ~SYNC_POL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign lead = pix_en && (sync_q == SYNC_POL) && (prev_q != SYNC_POL);

endmodule
`default_nettype wire

// File: rtl/vga_timing_det.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_det
// Purpose  : Measures incoming VGA hsync/vsync timing, locks when it matches
//            the nominal mode and reports the active-area pixel position.
// Ports    : sys_clk, sys_rst      - clock, synchronous active-high reset
//            pix_en                - pixel-rate enable
//            hsync, vsync          - asynchronous sync inputs
//            pix_x, pix_y          - active-area coordinate (0 outside)
//            active                - locked and inside the visible window
//            h_total, v_total      - length of last complete line / frame
//            locked                - timing matches nominal
//            frame_start           - one-cycle pulse on a vsync leading edge
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_det
   import vga_pkg::*;
#(
   parameter int unsigned H_SYNC   = C_H_SYNC,
   parameter int unsigned H_BACK   = C_H_BACK,
   parameter int unsigned H_ACTIVE = C_H_ACTIVE,
   parameter int unsigned H_TOTAL  = C_H_TOTAL,
   parameter int unsigned V_SYNC   = C_V_SYNC,
   parameter int unsigned V_BACK   = C_V_BACK,
   parameter int unsigned V_ACTIVE = C_V_ACTIVE,
   parameter int unsigned V_TOTAL  = C_V_TOTAL,
   parameter logic        SYNC_POL = C_SYNC_POL
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        active,
   output logic [10:0] h_total,
   output logic [9:0]  v_total,
   output logic        locked,
   output logic        frame_start
);

   localparam logic [11:0] H_WIN_LO  = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_WIN_HI  = 12'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [11:0] H_TOT_W   = 12'(H_TOTAL);
   localparam logic [10:0] V_WIN_LO  = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] V_WIN_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [10:0] V_TOT_W   = 11'(V_TOTAL);
   localparam logic [9:0]  H_OFF10   = 10'(H_SYNC + H_BACK);
   localparam logic [9:0]  V_OFF10   = 10'(V_SYNC + V_BACK);

   logic        h_lead, v_lead;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [10:0] h_total_q, h_total_d;
   logic [9:0]  v_total_q, v_total_d;
   logic [11:0] h_cnt_inc;
   logic [10:0] v_cnt_inc;
   logic        h_line_bad, v_frame_bad, cnt_sat;
   lock_state_t state_q, state_d;
   logic        mis_q, mis_d;
   logic        locked_q, locked_d;
   logic        active_q, active_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [9:0]  pix_y_q, pix_y_d;
   logic        h_in, v_in;

   sync_edge #(.SYNC_POL(SYNC_POL)) u_hsync (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .pix_en   (pix_en),
      .async_in (hsync),
      .lead     (h_lead)
   );

   sync_edge #(.SYNC_POL(SYNC_POL)) u_vsync (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .pix_en   (pix_en),
      .async_in (vsync),
      .lead     (v_lead)
   );

   // Widened increments so the compare against the nominal totals cannot
   // alias when a counter sits at its ceiling.
   assign h_cnt_inc   = {1'b0, h_cnt_q} + 12'd1;
   assign v_cnt_inc   = {1'b0, v_cnt_q} + 11'd1;
   assign h_line_bad  = h_lead && (h_cnt_inc != H_TOT_W);
   assign v_frame_bad = v_lead && (v_cnt_inc != V_TOT_W);
   assign cnt_sat     = pix_en && ((h_cnt_q == C_H_CNT_MAX) || (v_cnt_q == C_V_CNT_MAX));

   always_comb begin : counters
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      h_total_d = h_total_q;
      v_total_d = v_total_q;
      if (h_lead) begin
         h_cnt_d   = '0;
         h_total_d = h_cnt_inc[10:0];
      end else if (pix_en && (h_cnt_q != C_H_CNT_MAX)) begin
         h_cnt_d = h_cnt_inc[10:0];
      end
      // vsync restarts the frame even when an hsync edge lands on the same pixel
      if (v_lead) begin
         v_cnt_d   = '0;
         v_total_d = v_cnt_inc[9:0];
      end else if (h_lead && (v_cnt_q != C_V_CNT_MAX)) begin
         v_cnt_d = v_cnt_inc[9:0];
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      mis_d   = mis_q;
      case (state_q)
         ST_SEARCH: begin
            if (v_lead) begin
               state_d = ST_TRACK;
               mis_d   = 1'b0;
            end
         end
         ST_TRACK: begin
            if (v_lead) begin
               // A bad line ending on this very pixel still spoils the frame
               if (!mis_q && !h_line_bad && !v_frame_bad) begin
                  state_d = ST_LOCKED;
               end
               mis_d = 1'b0;
            end else if (h_line_bad) begin
               mis_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (h_line_bad || v_frame_bad || cnt_sat) begin
               state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   always_comb begin : fsm_out
      // Computed from next-state values so the registered outputs line up
      // with the counter values they describe.
      locked_d = (state_d == ST_LOCKED);
      h_in     = ({1'b0, h_cnt_d} >= H_WIN_LO) && ({1'b0, h_cnt_d} < H_WIN_HI);
      v_in     = ({1'b0, v_cnt_d} >= V_WIN_LO) && ({1'b0, v_cnt_d} < V_WIN_HI);
      active_d = locked_d && h_in && v_in;
      pix_x_d  = '0;
      pix_y_d  = '0;
      if (active_d) begin
         pix_x_d = h_cnt_d[9:0] - H_OFF10;
         pix_y_d = v_cnt_d - V_OFF10;
      end
   end

   always_ff @(posedge sys_clk) begin : state_reg
      if (sys_rst) begin
         state_q   <= ST_SEARCH;
         mis_q     <= 1'b0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         h_total_q <= '0;
         v_total_q <= '0;
         locked_q  <= 1'b0;
         active_q  <= 1'b0;
         pix_x_q   <= '0;
         pix_y_q   <= '0;
      end else begin
         state_q   <= state_d;
         mis_q     <= mis_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         h_total_q <= h_total_d;
         v_total_q <= v_total_d;
         locked_q  <= locked_d;
         active_q  <= active_d;
         pix_x_q   <= pix_x_d;
         pix_y_q   <= pix_y_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign active      = active_q;
   assign h_total     = h_total_q;
   assign v_total     = v_total_q;
   assign locked      = locked_q;
   assign frame_start = v_lead;

endmodule
`default_nettype wire
